// File: rtl/arcade_input_mapper.sv
// Arcade input mapper: merges PS/2 key events and two joystick words into
// per-player control vectors, with SOCD cleaning on the direction pairs,
// per-button autofire, coin pulse stretching and an optional player swap.
//
// Internal per-player "raw" vectors use the joystick bit layout:
//   [0] R, [1] L, [2] D, [3] U, [4+i] button i, [4+N] start, [5+N] coin.
// Control outputs use the layout {buttons, up, down, right, left}.
module arcade_input_mapper #(
    parameter int NUM_BUTTONS   = 2,
    parameter int COIN_PULSE    = 4800000,
    parameter int AUTOFIRE_HALF = 1600000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic [15:0]            joystick_0,
    input  logic [15:0]            joystick_1,
    input  logic [1:0]             socd_mode,
    input  logic [NUM_BUTTONS-1:0] autofire_mask,
    input  logic                   swap,
    output logic [3+NUM_BUTTONS:0] p1_ctrl,
    output logic [3+NUM_BUTTONS:0] p2_ctrl,
    output logic                   start_1,
    output logic                   start_2,
    output logic                   coin_1,
    output logic                   coin_2
);

    // Width of one player's raw vector and of one control output.
    localparam int KEY_W     = 6 + NUM_BUTTONS;
    localparam int CTRL_W    = 4 + NUM_BUTTONS;
    localparam int BIT_START = 4 + NUM_BUTTONS;
    localparam int BIT_COIN  = 5 + NUM_BUTTONS;

    localparam logic [23:0] LP_COIN_LOAD = 24'(COIN_PULSE);
    localparam logic [23:0] LP_AF_LAST   = 24'(AUTOFIRE_HALF - 1);

    // Scan code tables, index [player][member]. Direction members are in
    // raw order R, L, D, U (element 0 is the rightmost byte).
    localparam logic [1:0][3:0][7:0] LP_DIR_CODE = {
        {8'h2D, 8'h2B, 8'h23, 8'h34},   // player 2: U D L R
        {8'h75, 8'h72, 8'h6B, 8'h74}    // player 1: U D L R
    };
    localparam logic [1:0][3:0][7:0] LP_BTN_CODE = {
        {8'h1D, 8'h15, 8'h1B, 8'h1C},   // player 2: b3 b2 b1 b0
        {8'h12, 8'h29, 8'h11, 8'h14}    // player 1: b3 b2 b1 b0
    };
    localparam logic [1:0][7:0] LP_START_CODE = {8'h1E, 8'h16};
    localparam logic [1:0][7:0] LP_COIN_CODE  = {8'h36, 8'h2E};

    // PS/2 event tracking and key states
    logic                       r_toggle;
    logic                       w_event;
    logic [1:0][KEY_W-1:0]      r_key;
    logic [1:0][KEY_W-1:0]      w_key_mask;

    // Raw merged inputs and their edge history
    logic [1:0][KEY_W-1:0]      w_joy;
    logic [1:0][KEY_W-1:0]      w_raw;
    logic [1:0][KEY_W-1:0]      w_rise;
    logic [1:0][KEY_W-1:0]      r_raw_prev;

    // SOCD: a set bit means right (resp. down) won most recently
    logic [1:0]                 r_lw_lr;
    logic [1:0]                 r_lw_ud;
    logic [1:0]                 w_lw_lr_next;
    logic [1:0]                 w_lw_ud_next;
    logic [1:0][3:0]            w_dir;

    // Autofire
    logic [1:0][NUM_BUTTONS-1:0][23:0] r_af_cnt;
    logic [1:0][NUM_BUTTONS-1:0][23:0] w_af_cnt_next;
    logic [1:0][NUM_BUTTONS-1:0]       r_af_phase;
    logic [1:0][NUM_BUTTONS-1:0]       w_af_phase_next;
    logic [1:0][NUM_BUTTONS-1:0]       w_btn;

    // Coin stretching, start and assembled control vectors
    logic [1:0][23:0]           r_coin_cnt;
    logic [1:0][23:0]           w_coin_cnt_next;
    logic [1:0]                 w_coin;
    logic [1:0]                 w_start;
    logic [1:0][CTRL_W-1:0]     w_ctrl;

    // Joystick bits above the mapped range and the extended flag carry no
    // meaning here; they are folded into one sink signal.
    logic                       w_unused;

    assign w_joy[0] = joystick_0[KEY_W-1:0];
    assign w_joy[1] = joystick_1[KEY_W-1:0];
    assign w_unused = ^{joystick_0[15:KEY_W], joystick_1[15:KEY_W], ps2_key[8]};

    // An event is any change of the toggle bit since the previous edge.
    assign w_event = ps2_key[10] ^ r_toggle;

    // Decode the scan code into a one-hot mask over each player's raw vector;
    // unmapped codes and buttons beyond NUM_BUTTONS leave the mask empty.
    always_comb begin
        // NOTE: every combinational output is given a default before any
        // conditional assignment, so no path can leave it holding a value
        // (which would infer a latch).
        w_key_mask = '0;
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 4; d++) begin
                if (ps2_key[7:0] == LP_DIR_CODE[p][d]) w_key_mask[p][d] = 1'b1;
            end
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                if (ps2_key[7:0] == LP_BTN_CODE[p][b]) w_key_mask[p][4+b] = 1'b1;
            end
            if (ps2_key[7:0] == LP_START_CODE[p]) w_key_mask[p][BIT_START] = 1'b1;
            if (ps2_key[7:0] == LP_COIN_CODE[p])  w_key_mask[p][BIT_COIN]  = 1'b1;
        end
    end

    // Track the toggle bit and load the addressed key state on an event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_toggle <= 1'b0;
            r_key    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge.
            r_toggle <= ps2_key[10];
            if (w_event) begin
                for (int p = 0; p < 2; p++) begin
                    r_key[p] <= (r_key[p] & ~w_key_mask[p])
                              | (w_key_mask[p] & {KEY_W{ps2_key[9]}});
                end
            end
        end
    end

    // Merge keyboard and joystick, and find rising edges.
    always_comb begin
        w_raw  = '0;
        w_rise = '0;
        for (int p = 0; p < 2; p++) begin
            w_raw[p]  = r_key[p] | w_joy[p];
            w_rise[p] = w_raw[p] & ~r_raw_prev[p];
        end
    end

    // SOCD cleaning of L/R and U/D; last-wins history includes this edge.
    always_comb begin
        w_lw_lr_next = r_lw_lr;
        w_lw_ud_next = r_lw_ud;
        w_dir        = '0;
        for (int p = 0; p < 2; p++) begin
            // Left/up take precedence when both members rise together.
            if (w_rise[p][1])      w_lw_lr_next[p] = 1'b0;
            else if (w_rise[p][0]) w_lw_lr_next[p] = 1'b1;
            if (w_rise[p][3])      w_lw_ud_next[p] = 1'b0;
            else if (w_rise[p][2]) w_lw_ud_next[p] = 1'b1;

            // Output order: [0] L, [1] R, [2] D, [3] U.
            w_dir[p] = {w_raw[p][3], w_raw[p][2], w_raw[p][0], w_raw[p][1]};

            if (w_raw[p][0] && w_raw[p][1]) begin
                case (socd_mode)
                    2'd1:    w_dir[p][1:0] = 2'b00;
                    2'd2:    w_dir[p][1:0] = w_lw_lr_next[p] ? 2'b10 : 2'b01;
                    default: w_dir[p][1:0] = 2'b11;
                endcase
            end
            if (w_raw[p][2] && w_raw[p][3]) begin
                case (socd_mode)
                    2'd1:    w_dir[p][3:2] = 2'b00;
                    2'd2:    w_dir[p][3:2] = w_lw_ud_next[p] ? 2'b01 : 2'b10;
                    default: w_dir[p][3:2] = 2'b11;
                endcase
            end
        end
    end

    // Autofire: restart on a press, advance only while held with mask set.
    always_comb begin
        w_af_cnt_next   = r_af_cnt;
        w_af_phase_next = r_af_phase;
        w_btn           = '0;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                if (w_rise[p][4+b]) begin
                    w_af_cnt_next[p][b]   = '0;
                    w_af_phase_next[p][b] = 1'b1;
                end else if (w_raw[p][4+b] && autofire_mask[b]) begin
                    if (r_af_cnt[p][b] == LP_AF_LAST) begin
                        w_af_cnt_next[p][b]   = '0;
                        w_af_phase_next[p][b] = ~r_af_phase[p][b];
                    end else begin
                        w_af_cnt_next[p][b] = r_af_cnt[p][b] + 24'd1;
                    end
                end
                // The mask is applied to the output directly, so clearing it
                // mid-hold falls back to the plain button on the next edge.
                w_btn[p][b] = (w_raw[p][4+b] && autofire_mask[b])
                            ? w_af_phase_next[p][b] : w_raw[p][4+b];
            end
        end
    end

    // Coin stretching, start pass-through and control vector assembly.
    always_comb begin
        w_coin_cnt_next = r_coin_cnt;
        w_coin          = '0;
        w_start         = '0;
        w_ctrl          = '0;
        for (int p = 0; p < 2; p++) begin
            // A press always reloads, even while a pulse is still running.
            if (w_rise[p][BIT_COIN])        w_coin_cnt_next[p] = LP_COIN_LOAD;
            else if (r_coin_cnt[p] != '0)   w_coin_cnt_next[p] = r_coin_cnt[p] - 24'd1;
            // Using the next count makes the pulse exactly COIN_PULSE edges
            // long, counting the edge of the press itself.
            w_coin[p]  = w_raw[p][BIT_COIN] | (w_coin_cnt_next[p] != '0);
            w_start[p] = w_raw[p][BIT_START];
            w_ctrl[p]  = {w_btn[p], w_dir[p]};
        end
    end

    // Edge history, last-wins, autofire and coin state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: counters and phases are cleared by reset as well, so a
            // reset aborts a running coin pulse or autofire sequence, and the
            // cleared edge history turns any held input into a fresh press.
            r_raw_prev <= '0;
            r_lw_lr    <= '0;
            r_lw_ud    <= '0;
            r_af_cnt   <= '0;
            r_af_phase <= '0;
            r_coin_cnt <= '0;
        end else begin
            r_raw_prev <= w_raw;
            r_lw_lr    <= w_lw_lr_next;
            r_lw_ud    <= w_lw_ud_next;
            r_af_cnt   <= w_af_cnt_next;
            r_af_phase <= w_af_phase_next;
            r_coin_cnt <= w_coin_cnt_next;
        end
    end

    // Output registers; swap only chooses which player feeds which port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_ctrl <= '0;
            p2_ctrl <= '0;
            start_1 <= 1'b0;
            start_2 <= 1'b0;
            coin_1  <= 1'b0;
            coin_2  <= 1'b0;
        end else if (swap) begin
            p1_ctrl <= w_ctrl[1];
            p2_ctrl <= w_ctrl[0];
            start_1 <= w_start[1];
            start_2 <= w_start[0];
            coin_1  <= w_coin[1];
            coin_2  <= w_coin[0];
        end else begin
            p1_ctrl <= w_ctrl[0];
            p2_ctrl <= w_ctrl[1];
            start_1 <= w_start[0];
            start_2 <= w_start[1];
            coin_1  <= w_coin[0];
            coin_2  <= w_coin[1];
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Testbench for arcade_input_mapper: directed scenarios followed by random
// stimulus, compared every edge against a behavioural model that reasons in
// terms of press timestamps, hold ages and pulse end times.
module tb_arcade_input_mapper;

    localparam int NB = 2;
    localparam int CP = 10;
    localparam int AH = 3;
    localparam int CW = 4 + NB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [10:0]   ps2_key = '0;
    logic [15:0]   joystick_0 = '0;
    logic [15:0]   joystick_1 = '0;
    logic [1:0]    socd_mode = 2'd0;
    logic [NB-1:0] autofire_mask = '0;
    logic          swap = 1'b0;
    logic [CW-1:0] p1_ctrl;
    logic [CW-1:0] p2_ctrl;
    logic          start_1;
    logic          start_2;
    logic          coin_1;
    logic          coin_2;

    arcade_input_mapper #(
        .NUM_BUTTONS  (NB),
        .COIN_PULSE   (CP),
        .AUTOFIRE_HALF(AH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_key      (ps2_key),
        .joystick_0   (joystick_0),
        .joystick_1   (joystick_1),
        .socd_mode    (socd_mode),
        .autofire_mask(autofire_mask),
        .swap         (swap),
        .p1_ctrl      (p1_ctrl),
        .p2_ctrl      (p2_ctrl),
        .start_1      (start_1),
        .start_2      (start_2),
        .coin_1       (coin_1),
        .coin_2       (coin_2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Function index per player: 0 R, 1 L, 2 D, 3 U, 4..7 buttons, 8 start, 9 coin.
    logic [7:0] key_code [2][10] = '{
        '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h12, 8'h16, 8'h2E},
        '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1D, 8'h1E, 8'h36}
    };

    // Reference model state
    bit            key_held   [2][10];
    bit            prev_raw   [2][10];
    longint        last_rise  [2][10];
    int            af_age     [2][NB];
    longint        coin_until [2];
    bit            prev_tog;
    longint        edge_no = 0;
    logic [CW-1:0] exp_p1, exp_p2;
    logic          exp_s1, exp_s2, exp_c1, exp_c2;

    function automatic int joy_pos(input int fn);
        if (fn < 8)  return fn;
        if (fn == 8) return 4 + NB;
        return 5 + NB;
    endfunction

    function automatic bit fn_used(input int fn);
        return !(fn >= 4 && fn < 8 && fn - 4 >= NB);
    endfunction

    // Returns {first_out, second_out}; first is left/up and wins ties.
    function automatic logic [1:0] resolve(input bit first, input bit second,
                                           input longint t_first, input longint t_second);
        if (first && second) begin
            if (socd_mode == 2'd1) return 2'b00;
            if (socd_mode == 2'd2) return (t_first >= t_second) ? 2'b10 : 2'b01;
        end
        return {first, second};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int f = 0; f < 10; f++) begin
                key_held[p][f]  = 1'b0;
                prev_raw[p][f]  = 1'b0;
                last_rise[p][f] = -1;
            end
            for (int b = 0; b < NB; b++) af_age[p][b] = 0;
            coin_until[p] = -1;
        end
        prev_tog = 1'b0;
        exp_p1 = '0; exp_p2 = '0;
        exp_s1 = 1'b0; exp_s2 = 1'b0; exp_c1 = 1'b0; exp_c2 = 1'b0;
    endtask

    task automatic model_edge();
        bit            raw [2][10];
        logic [CW-1:0] ctrl [2];
        bit            st [2];
        bit            cn [2];
        logic [15:0]   joy;
        logic [1:0]    lr, ud;
        for (int p = 0; p < 2; p++) begin
            joy = (p == 0) ? joystick_0 : joystick_1;
            for (int f = 0; f < 10; f++) begin
                raw[p][f] = fn_used(f) && (key_held[p][f] || joy[joy_pos(f)]);
                if (raw[p][f] && !prev_raw[p][f]) last_rise[p][f] = edge_no;
            end
            lr = resolve(raw[p][1], raw[p][0], last_rise[p][1], last_rise[p][0]);
            ud = resolve(raw[p][3], raw[p][2], last_rise[p][3], last_rise[p][2]);
            ctrl[p] = '0;
            ctrl[p][0] = lr[1];
            ctrl[p][1] = lr[0];
            ctrl[p][2] = ud[0];
            ctrl[p][3] = ud[1];
            for (int b = 0; b < NB; b++) begin
                if (raw[p][4+b] && !prev_raw[p][4+b]) af_age[p][b] = 0;
                else if (raw[p][4+b] && autofire_mask[b]) af_age[p][b]++;
                if (raw[p][4+b] && autofire_mask[b])
                    ctrl[p][4+b] = ((af_age[p][b] / AH) % 2) == 0;
                else
                    ctrl[p][4+b] = raw[p][4+b];
            end
            st[p] = raw[p][8];
            if (raw[p][9] && !prev_raw[p][9]) coin_until[p] = edge_no + CP;
            cn[p] = raw[p][9] || (edge_no < coin_until[p]);
            for (int f = 0; f < 10; f++) prev_raw[p][f] = raw[p][f];
        end
        if (swap) begin
            exp_p1 = ctrl[1]; exp_p2 = ctrl[0];
            exp_s1 = st[1];   exp_s2 = st[0];
            exp_c1 = cn[1];   exp_c2 = cn[0];
        end else begin
            exp_p1 = ctrl[0]; exp_p2 = ctrl[1];
            exp_s1 = st[0];   exp_s2 = st[1];
            exp_c1 = cn[0];   exp_c2 = cn[1];
        end
        if (ps2_key[10] != prev_tog) begin
            for (int p = 0; p < 2; p++)
                for (int f = 0; f < 10; f++)
                    if (ps2_key[7:0] == key_code[p][f] && fn_used(f))
                        key_held[p][f] = ps2_key[9];
        end
        prev_tog = ps2_key[10];
        edge_no++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".p1"}, p1_ctrl, exp_p1);
        check({tag, ".p2"}, p2_ctrl, exp_p2);
        check({tag, ".misc"}, {start_1, start_2, coin_1, coin_2},
              {exp_s1, exp_s2, exp_c1, exp_c2});
    endtask

    // One clock edge: model advances with the DUT, outputs sampled 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic press(input logic [7:0] code, input bit pressed);
        ps2_key = {~ps2_key[10], pressed, 1'b0, code};
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int          hi;
        logic [11:0] pat;
        logic [15:0] flip;
        logic [7:0]  code;

        // Reset state
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all("reset");
        reset_n = 1'b1;

        // Keyboard up for player 1: two edges of latency each way
        press(8'h75, 1'b1);
        step("kbd_e1");
        check("kbd_up_after1", p1_ctrl[3], 1'b0);
        step("kbd_e2");
        check("kbd_up_after2", p1_ctrl[3], 1'b1);
        press(8'h75, 1'b0);
        step("kbd_rel_e1");
        step("kbd_rel_e2");
        check("kbd_up_released", p1_ctrl[3], 1'b0);

        // Last-wins: left held, right pressed later, then right released
        socd_mode = 2'd2;
        joystick_0[1] = 1'b1;
        repeat (5) step("lw_hold");
        joystick_0[0] = 1'b1;
        step("lw_both");
        check("lw_right_wins", p1_ctrl[1:0], 2'b10);
        joystick_0[0] = 1'b0;
        step("lw_rel");
        check("lw_left_back", p1_ctrl[1:0], 2'b01);
        joystick_0[1] = 1'b0;
        step("lw_idle");

        // Neutral for player 2 up+down, then pass-through
        socd_mode = 2'd1;
        press(8'h2D, 1'b1);
        step("neu_a");
        press(8'h2B, 1'b1);
        step("neu_b");
        step("neu_c");
        check("neutral_ud", p2_ctrl[3:2], 2'b00);
        socd_mode = 2'd0;
        step("pass");
        check("pass_ud", p2_ctrl[3:2], 2'b11);
        press(8'h2D, 1'b0);
        step("neu_rel_a");
        press(8'h2B, 1'b0);
        step("neu_rel_b");
        step("neu_rel_c");

        // Coin: one-cycle pulse stretched to exactly CP edges
        joystick_0[7] = 1'b1;
        step("coin1");
        hi = int'(coin_1);
        joystick_0[7] = 1'b0;
        repeat (14) begin
            step("coin1");
            hi += int'(coin_1);
        end
        check("coin_width", hi, CP);

        // Coin: second press 5 edges in reloads the pulse
        joystick_0[7] = 1'b1;
        step("coin2");
        hi = int'(coin_1);
        for (int i = 1; i < 25; i++) begin
            joystick_0[7] = (i == 5);
            step("coin2");
            hi += int'(coin_1);
        end
        check("coin_reload_width", hi, CP + 5);

        // Autofire on button 0 only, button 1 steady
        autofire_mask = 2'b01;
        joystick_0[5:4] = 2'b11;
        pat = 12'b111000111000;
        for (int i = 0; i < 12; i++) begin
            step("af");
            check($sformatf("af_b0[%0d]", i), p1_ctrl[4], pat[11-i]);
            check($sformatf("af_b1[%0d]", i), p1_ctrl[5], 1'b1);
        end
        joystick_0[5:4] = 2'b00;
        step("af_rel");

        // Swap: player 1 start key shows up on start_2
        swap = 1'b1;
        press(8'h16, 1'b1);
        step("swap_a");
        step("swap_b");
        check("swap_start", {start_1, start_2}, 2'b01);
        press(8'h16, 1'b0);
        step("swap_c");
        swap = 1'b0;
        step("swap_d");

        // Reset mid coin pulse clears it at once; toggle=1 at release is an event
        joystick_0[7] = 1'b1;
        step("coin_abort_a");
        joystick_0[7] = 1'b0;
        step("coin_abort_b");
        step("coin_abort_c");
        check("coin_mid", coin_1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("coin_abort", coin_1, 1'b0);
        model_reset();
        compare_all("rst_mid");
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h74};
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("rel_e1");
        step("rel_e2");
        check("toggle_at_release", p1_ctrl[1], 1'b1);
        press(8'h74, 1'b0);
        step("rel_e3");
        step("rel_e4");

        // Random stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            flip = '0;
            for (int b = 0; b < 16; b++) if ($urandom_range(0, 9) == 0) flip[b] = 1'b1;
            joystick_0 = joystick_0 ^ flip;
            flip = '0;
            for (int b = 0; b < 16; b++) if ($urandom_range(0, 9) == 0) flip[b] = 1'b1;
            joystick_1 = joystick_1 ^ flip;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) == 0) code = 8'($urandom_range(0, 255));
                else code = key_code[$urandom_range(0, 1)][$urandom_range(0, 9)];
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), code};
            end
            if (n % 64 == 0) socd_mode = 2'($urandom_range(0, 3));
            if (n % 40 == 0) autofire_mask = NB'($urandom_range(0, (1 << NB) - 1));
            if ($urandom_range(0, 49) == 0) swap = ~swap;
            if ($urandom_range(0, 399) == 0) pulse_reset();
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
